// File: rtl/head_table_wr_arb.sv
// Head table write-port arbiter: round-robin among write requesters, plus a
// full-table clear sweep that has priority over all requesters.
//
// state   | meaning
// ST_IDLE | arbitrate requesters, accept one write per cycle
// ST_INIT | sweep every address with a zero word, requesters stalled
module head_table_wr_arb #(
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 17,
  parameter int NUM_REQ = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         init_start_i,
  output logic                         init_busy_o,
  output logic                         init_done_o,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*D_WIDTH-1:0]   req_data_i,
  output logic                         wr_en_o,
  output logic [A_WIDTH-1:0]           wr_addr_o,
  output logic [D_WIDTH-1:0]           wr_data_o
);

  localparam int LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [A_WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic {ST_IDLE, ST_INIT} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [A_WIDTH-1:0]   r_cnt;
  logic [LG_W-1:0]      r_last_grant;
  logic [LG_W-1:0]      w_gidx;
  logic [LG_W-1:0]      w_idx;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_found;
  logic                 w_xfer;
  logic [A_WIDTH-1:0]   w_sel_addr;
  logic [D_WIDTH-1:0]   w_sel_data;
  logic                 r_wr_en;
  logic [A_WIDTH-1:0]   r_wr_addr;
  logic [D_WIDTH-1:0]   r_wr_data;
  logic                 r_busy;
  logic                 r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = '0;
    w_gidx      = r_last_grant;
    w_idx       = '0;
    w_found     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (init_start_i) begin
          w_state_nxt = ST_INIT;
        end else if (!rst_i) begin
          // Search starts one past the last winner so every requester gets a turn.
          for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = LG_W'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && req_valid_i[w_idx]) begin
              w_grant[w_idx] = 1'b1;
              w_gidx         = w_idx;
              w_found        = 1'b1;
            end
          end
        end
      end
      ST_INIT: begin
        if (r_cnt == CNT_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_xfer     = w_found;
  assign w_sel_addr = req_addr_i[int'(w_gidx)*A_WIDTH +: A_WIDTH];
  assign w_sel_data = req_data_i[int'(w_gidx)*D_WIDTH +: D_WIDTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= LG_W'(NUM_REQ - 1);
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (init_start_i) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
          end else if (w_xfer) begin
            r_wr_en      <= 1'b1;
            r_wr_addr    <= w_sel_addr;
            r_wr_data    <= w_sel_data;
            r_last_grant <= w_gidx;
          end
        end
        ST_INIT: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_cnt;
          r_wr_data <= '0;
          r_cnt     <= r_cnt + A_WIDTH'(1);
          if (r_cnt == CNT_LAST) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = w_grant;
  assign wr_en_o     = r_wr_en;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign init_busy_o = r_busy;
  assign init_done_o = r_done;

endmodule
